// File: rtl/bg_pixel_fetch.sv
`default_nettype none
// bg_pixel_fetch: prefetches the SDRAM background image into a small FIFO and
// serves one B/A/R/G pixel per active-video strobe; restarts on each vs rise.
module bg_pixel_fetch #(
  parameter int ADDR_W      = 25,
  parameter int DEPTH       = 8,
  parameter int FRAME_WORDS = 307200
) (
  input  logic              clk_50,
  input  logic              RESET_L,
  input  logic              enable,
  input  logic              ce_pix,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              vs,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic [3:0]        bg_r,
  output logic [3:0]        bg_g,
  output logic [3:0]        bg_b,
  output logic [3:0]        bg_a,
  output logic              bg_valid,
  output logic [7:0]        underrun_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [WC_W-1:0]  FRAME_C = WC_W'(FRAME_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               vs_q;
  logic               out_q, out_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        pix_q, pix_d;
  logic               valid_q, valid_d;
  logic [7:0]         urun_q, urun_d;
  logic [15:0]        fifo_q [DEPTH];

  logic vs_rise, ack_ok, pop, push, pop_hit;

  assign vs_rise = vs & ~vs_q;
  assign ack_ok  = mem_ack & out_q;
  assign pop     = ce_pix & ~hblank & ~vblank & (state_q == RUN);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    req_d   = 1'b0;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    valid_d = valid_q;
    urun_d  = urun_q;
    push    = 1'b0;
    pop_hit = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      out_d   = 1'b0;
      addr_d  = '0;
      wcnt_d  = '0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      pix_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          addr_d  = '0;
          wcnt_d  = '0;
          wr_d    = '0;
          rd_d    = '0;
          cnt_d   = '0;
        end
        FLUSH: begin
          if (ack_ok) begin
            out_d   = 1'b0;
            state_d = RUN;
          end
        end
        RUN: begin
          // The pop reads the head before any vs clear takes effect.
          if (pop) begin
            if (cnt_q != '0) begin
              pop_hit = 1'b1;
              pix_d   = fifo_q[rd_q];
              valid_d = 1'b1;
              rd_d    = rd_q + PTR_W'(1);
            end else begin
              pix_d   = '0;
              valid_d = 1'b0;
              if (urun_q != 8'hFF) urun_d = urun_q + 8'd1;
            end
          end
          if (vs_rise) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            wcnt_d = '0;
            if (out_q && !mem_ack) state_d = FLUSH;
            else                   out_d   = 1'b0;
          end else begin
            push  = ack_ok;
            if (push) wr_d = wr_q + PTR_W'(1);
            out_d = out_q & ~mem_ack;
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop_hit);
            // Reserve a slot for the word in flight so the FIFO cannot overflow.
            if (!out_d && (cnt_d < DEPTH_C) && (wcnt_q < FRAME_C)) begin
              req_d  = 1'b1;
              out_d  = 1'b1;
              addr_d = ADDR_W'({wcnt_q, 1'b0});
              wcnt_d = wcnt_q + WC_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      out_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      urun_q  <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs;
      out_q   <= out_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      urun_q  <= urun_d;
    end
  end

  always_ff @(posedge clk_50) begin
    if (push) fifo_q[wr_q] <= mem_data;
  end

  assign mem_req      = req_q;
  assign mem_addr     = addr_q;
  assign bg_b         = pix_q[15:12];
  assign bg_a         = pix_q[11:8];
  assign bg_r         = pix_q[7:4];
  assign bg_g         = pix_q[3:0];
  assign bg_valid     = valid_q;
  assign underrun_cnt = urun_q;

endmodule
`default_nettype wire

// File: doc/bg_pixel_fetch.md
# bg_pixel_fetch

Background-picture prefetcher between the SDRAM controller and the video mixer. It issues single-word reads of the 640x480 background image stored in SDRAM and buffers the words in a small FIFO. On each active-video pixel strobe it presents one 16-bit pixel as 4-bit B/A/R/G, so SDRAM latency never stalls the pixel stream. It restarts at address 0 on every vertical-sync rising edge.

## Interface
Parameters:
- ADDR_W, 25, SDRAM byte-address width
- DEPTH, 8, FIFO depth in 16-bit words (power of two, 4..32)
- FRAME_WORDS, 307200, words per frame (640*480)

Ports:
- clk_50  in  1  sole clock; all logic on its rising edge
- RESET_L  in  1  asynchronous active-low reset
- enable  in  1  background in use; 0 forces IDLE, no requests, zero outputs
- ce_pix  in  1  pixel strobe, one clk_50 cycle wide
- hblank  in  1  horizontal blank
- vblank  in  1  vertical blank
- vs  in  1  vertical sync, active high
- mem_req  out  1  one-cycle read-request pulse
- mem_addr  out  ADDR_W  byte address, held stable from mem_req until mem_ack
- mem_ack  in  1  read complete; mem_data valid this cycle
- mem_data  in  16  read data, packed {b[15:12], a[11:8], r[7:4], g[3:0]}
- bg_r, bg_g, bg_b, bg_a  out  4 each  current background pixel
- bg_valid  out  1  current pixel came from the FIFO (not an underrun)
- underrun_cnt  out  8  saturating count of pops that found the FIFO empty

## Operation
- States:
  - IDLE: enable=0.
  - FLUSH: draining a discarded request.
  - RUN: fetching and serving.
- Reset: all outputs 0, state IDLE, FIFO empty, address 0, underrun_cnt 0.
- IDLE -> RUN when enable=1. The FIFO is cleared and the address starts at 0.
- Any state -> IDLE when enable=0. An outstanding request is abandoned; a later mem_ack is ignored. Outputs go to 0.
- vs rising edge: detected every clk_50 cycle from a registered copy of vs, not gated by ce_pix.
  - FIFO cleared, address set to 0, word count set to 0.
  - If a request is outstanding, go to FLUSH. Its mem_ack data is discarded, then go to RUN.
  - Otherwise stay in RUN.
- Fetch rule in RUN:
  - At most one request outstanding.
  - mem_req pulses when no request is outstanding, FIFO occupancy < DEPTH, and fetched words < FRAME_WORDS.
  - mem_addr = 2*word index.
  - No wrap: fetching stops at the frame end until the next vs edge.
- Push: mem_ack in RUN writes mem_data into the FIFO and clears outstanding. Occupancy + outstanding never exceeds DEPTH, so overflow cannot occur.
- Pop: ce_pix & ~hblank & ~vblank & state==RUN.
  - FIFO non-empty: register the head into bg_* with bg_valid=1.
  - FIFO empty: bg_*=0, bg_valid=0, underrun_cnt increments, saturating at 255.
- When not popping, bg_* and bg_valid hold their values.
- underrun_cnt clears only on reset.

## Timing
- mem_req asserts at the earliest 1 cycle after entering RUN. It lasts exactly 1 cycle.
- After mem_ack, the next mem_req can come 1 cycle later.
- Pop-to-output latency: bg_* update on the clk_50 edge after the pop cycle.
- Push and pop in the same cycle: occupancy unchanged. There is no bypass: a pop on an empty FIFO with a simultaneous ack counts as an underrun, and the acked word is stored.
- vs edge and mem_ack in the same cycle: the ack data is discarded and the FIFO is empty next cycle; no FLUSH, since nothing is outstanding afterwards.
- vs edge and pop in the same cycle: the pop uses the pre-clear FIFO head.
- RESET_L assertion takes effect immediately, mid-transfer included. Release is synchronous to clk_50.

## Test plan
- Reset, then enable=1, SDRAM model acks 3 cycles after each req -> first mem_req with mem_addr=0. FIFO reaches 8 words. No mem_req while full.
- Active line with ce_pix every 2 cycles and data = word index -> bg_* follows 0x0000, 0x0001, ... unpacked as b=[15:12], a=[11:8], r=[7:4], g=[3:0]. bg_valid=1, underrun_cnt=0.
- Ack latency of 40 cycles with ce_pix every 2 cycles -> bg_valid drops, bg_*=0, underrun_cnt increments per empty pop and saturates at 255.
- vs rising while a request is outstanding -> FLUSH. Acked data is not shown. Next mem_req has mem_addr=0 and the FIFO refills from word 0.
- FRAME_WORDS=16 run with no vs -> last mem_addr=30 and no further requests until the vs edge, after which the address restarts at 0.
- enable dropped mid-fetch, then a late mem_ack -> bg_*=0 and no push. Re-enable restarts at mem_addr=0.
